// File: rtl/itch_pkg.sv
// Shared ITCH message constants and encoder state type.
// Imported by the Delete decoder and the message encoders.
package itch_pkg;

  localparam logic [7:0] ITCH_MSG_DELETE = 8'h44;
  localparam int         ITCH_LEN_DELETE = 9;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } enc_state_t;

endpackage

// File: rtl/delete_order_encoder_if.sv
// Request port and serialized byte stream of the Delete encoder.
// master drives requests; slave is the encoder itself.
interface delete_order_encoder_if;

  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_order_ref;
  logic [7:0]  byte_out;
  logic        valid_out;
  logic        msg_done;
  logic        busy;

  modport master (
    output req_valid,
    output req_order_ref,
    input  req_ready,
    input  byte_out,
    input  valid_out,
    input  msg_done,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_order_ref,
    output req_ready,
    output byte_out,
    output valid_out,
    output msg_done,
    output busy
  );

endinterface

// File: rtl/itch_req_fifo.sv
// Two-entry request FIFO shared by the ITCH encoders.
// full is registered from the next count, so it never lags a push.
module itch_req_fifo #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             full_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && (count != 2'd0);

  // Occupancy after this edge; a simultaneous push and pop cancel.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 2'd1;
    else if (do_pop && !do_push)
      count_next = count - 2'd1;
  end

  // Storage, wrapping pointers, count and the registered full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      full_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      count  <= count_next;
      full_q <= (count_next == 2'd2);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = full_q;
  assign empty = (count == 2'd0);

endmodule

// File: rtl/delete_order_encoder.sv
// Serializes queued order refs into 9-byte ITCH 'D' messages.
// Type byte first, then the reference MSB first, then a gap.
module delete_order_encoder
  import itch_pkg::*;
#(
  parameter logic [7:0] MSG_TYPE   = ITCH_MSG_DELETE,
  parameter int         MSG_LENGTH = ITCH_LEN_DELETE,
  parameter int         GAP_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst,
  delete_order_encoder_if.slave bus
);

  localparam logic [3:0] LAST     = 4'(MSG_LENGTH - 1);
  localparam logic [3:0] LAST_M1  = 4'(MSG_LENGTH - 2);
  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES - 1);

  enc_state_t  state, state_n;
  logic [3:0]  byte_cnt, byte_cnt_n;
  logic [3:0]  gap_cnt, gap_n;
  logic [63:0] ref_q, ref_n;
  logic [7:0]  byte_q, byte_n;
  logic        valid_q, valid_n;
  logic        done_q, done_n;
  logic        pop;
  logic        load;
  logic        full;
  logic        empty;
  logic [63:0] head;

  itch_req_fifo #(.WIDTH(64)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req_valid),
    .pop   (pop),
    .din   (bus.req_order_ref),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Next state and next registered outputs; the ref shifts out MSB first.
  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    gap_n      = gap_cnt;
    ref_n      = ref_q;
    byte_n     = 8'h00;
    valid_n    = 1'b0;
    done_n     = 1'b0;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        load = !empty;
      end
      SEND: begin
        if (byte_cnt == LAST) begin
          state_n = GAP;
          gap_n   = GAP_INIT;
        end else begin
          byte_n     = ref_q[63:56];
          ref_n      = {ref_q[55:0], 8'h00};
          byte_cnt_n = byte_cnt + 4'd1;
          valid_n    = 1'b1;
          done_n     = (byte_cnt == LAST_M1);
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) begin
          load    = !empty;
          state_n = IDLE;
        end else begin
          gap_n = gap_cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    pop = load;
    if (load) begin
      state_n    = SEND;
      ref_n      = head;
      byte_cnt_n = 4'd0;
      byte_n     = MSG_TYPE;
      valid_n    = 1'b1;
    end
  end

  // FSM, counters, shift register and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= 4'd0;
      gap_cnt  <= 4'd0;
      ref_q    <= 64'd0;
      byte_q   <= 8'h00;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      byte_cnt <= byte_cnt_n;
      gap_cnt  <= gap_n;
      ref_q    <= ref_n;
      byte_q   <= byte_n;
      valid_q  <= valid_n;
      done_q   <= done_n;
    end
  end

  assign bus.req_ready = !full;
  assign bus.byte_out  = byte_q;
  assign bus.valid_out = valid_q;
  assign bus.msg_done  = done_q;
  assign bus.busy      = (state != IDLE) || !empty;

endmodule

// File: tb/tb_delete_order_encoder.sv
// Directed and random checks of the Delete Order encoder.
// A scoreboard of accepted refs predicts every emitted byte.
module tb_delete_order_encoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  delete_order_encoder_if bus ();
  delete_order_encoder_if bus3 ();

  delete_order_encoder #(.GAP_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  delete_order_encoder #(.GAP_CYCLES(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  localparam logic [63:0] REF_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] REF_B = 64'h1122_3344_5566_7788;
  localparam logic [63:0] REF_L = 64'hDEAD_BEEF_0000_0042;

  int checks = 0;
  int errors = 0;
  logic [63:0] acc_q[$];
  int idx = 0;
  int emitted = 0;
  bit mon_en = 1'b0;

  function automatic logic [7:0] msg_byte(logic [63:0] r, int k);
    if (k == 0) return 8'h44;
    return 8'(r >> (8 * (8 - k)));
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Record every accepted request (inputs are stable at the edge).
  always @(posedge clk)
    if (!rst && bus.req_valid && bus.req_ready)
      acc_q.push_back(bus.req_order_ref);

  // Compare every output cycle of the GAP=1 instance with the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.valid_out) begin
        if (acc_q.size() == 0) begin
          check("spurious_valid", bus.valid_out, 0);
        end else begin
          check("mon_byte", bus.byte_out, msg_byte(acc_q[0], idx));
          check("mon_done", bus.msg_done, idx == 8);
          idx++;
          if (idx == 9) begin
            idx = 0;
            void'(acc_q.pop_front());
            emitted++;
          end
        end
      end else begin
        check("idle_byte", bus.byte_out, 0);
        check("idle_done", bus.msg_done, 0);
      end
    end
  end

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic push_req(input bit sel, input logic [63:0] r);
    int n;
    n = 0;
    if (sel) begin
      bus3.req_valid = 1'b1;
      bus3.req_order_ref = r;
      while (!bus3.req_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
    end else begin
      bus.req_valid = 1'b1;
      bus.req_order_ref = r;
      while (!bus.req_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check("accept_timeout", n < 200, 1);
    @(negedge clk);
    if (sel) bus3.req_valid = 1'b0;
    else bus.req_valid = 1'b0;
  endtask

  initial begin
    int n;
    int gaps;
    int nb;
    int dones;
    int em0;
    int acc;
    int cyc;
    bit a;
    bit expv;
    logic [63:0] got;

    bus.req_valid = 1'b0;
    bus.req_order_ref = '0;
    bus3.req_valid = 1'b0;
    bus3.req_order_ref = '0;

    // Reset values
    #1 rst = 1'b1;
    #1;
    check("rst_byte", bus.byte_out, 0);
    check("rst_valid", bus.valid_out, 0);
    check("rst_done", bus.msg_done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.req_ready, 1);
    check("rst_ready3", bus3.req_ready, 1);
    check("rst_busy3", bus3.busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single message: latency, byte order, msg_done placement
    push_req(0, REF_A);
    check("t1_latency", bus.valid_out, 0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("t1_byte", bus.byte_out, msg_byte(REF_A, k));
      check("t1_valid", bus.valid_out, 1);
      check("t1_done", bus.msg_done, k == 8);
    end
    @(negedge clk);
    check("t1_after_valid", bus.valid_out, 0);
    check("t1_after_byte", bus.byte_out, 0);
    repeat (3) @(negedge clk);
    check("t1_busy", bus.busy, 0);

    // Three back-to-back requests
    em0 = emitted;
    push_req(0, 64'd1);
    push_req(0, 64'd2);
    push_req(0, 64'd3);
    check("t2_ready_full", bus.req_ready, 0);
    check("t2_busy", bus.busy, 1);
    for (int k = 0; k < 35; k++) begin
      expv = (k < 8) || (k >= 9 && k < 18) || (k >= 19 && k < 28);
      check("t2_valid_pattern", bus.valid_out, expv);
      @(negedge clk);
    end
    check("t2_emitted", emitted - em0, 3);
    check("t2_ready_end", bus.req_ready, 1);

    // GAP_CYCLES=3 instance: idle gap between two messages
    push_req(1, REF_A);
    push_req(1, REF_B);
    n = 0;
    while (!bus3.msg_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t3_done_timeout", n < 50, 1);
    check("t3_last_byte", bus3.byte_out, REF_A[7:0]);
    gaps = 0;
    @(negedge clk);
    while (!bus3.valid_out && gaps < 20) begin
      gaps++;
      @(negedge clk);
    end
    check("t3_gap_cycles", gaps, 3);
    check("t3_next_type", bus3.byte_out, 8'h44);
    @(negedge clk);
    check("t3_next_b1", bus3.byte_out, REF_B[63:56]);
    repeat (12) @(negedge clk);

    // Reset mid-message with a second request queued
    push_req(0, REF_A);
    push_req(0, REF_B);
    repeat (4) @(negedge clk);
    check("t4_pre_byte4", bus.byte_out, REF_A[39:32]);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t4_byte", bus.byte_out, 0);
    check("t4_valid", bus.valid_out, 0);
    check("t4_done", bus.msg_done, 0);
    check("t4_busy", bus.busy, 0);
    check("t4_ready", bus.req_ready, 1);
    acc_q.delete();
    idx = 0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.valid_out) n++;
    end
    check("t4_no_bytes", n, 0);
    check("t4_busy_after", bus.busy, 0);
    check("t4_ready_after", bus.req_ready, 1);
    mon_en = 1'b1;

    // Loopback-style parse of one message
    push_req(0, REF_L);
    got = '0;
    nb = 0;
    dones = 0;
    n = 0;
    while (nb < 9 && n < 40) begin
      @(negedge clk);
      if (bus.valid_out) begin
        if (nb == 0) check("t5_type", bus.byte_out, 8'h44);
        else got = {got[55:0], bus.byte_out};
        if (bus.msg_done) dones++;
        nb++;
      end
      n++;
    end
    check("t5_len", nb, 9);
    check("t5_ref", got, REF_L);
    check("t5_done_once", dones, 1);
    @(negedge clk);
    check("t5_no_extra", bus.valid_out, 0);

    // Random request traffic: 1000 accepted refs
    em0 = emitted;
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 40000) begin
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_order_ref = {$urandom, $urandom};
      a = bus.req_valid && bus.req_ready;
      @(negedge clk);
      if (a) acc++;
      cyc++;
    end
    bus.req_valid = 1'b0;
    check("t6_accepts", acc, 1000);
    n = 0;
    while ((acc_q.size() != 0 || bus.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_drained", acc_q.size(), 0);
    check("t6_emitted", emitted - em0, 1000);
    check("t6_idle", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
